// File: rtl/vga_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_ctrl_pkg
//  Purpose  : Shared constants, mode encoding and the step/clamp helper used
//             by the vgadriver front-panel controller.
//  Contents : H_ACTIVE, V_ACTIVE, BOX_SIZE, STEP, mode_e, X_MAX/Y_MAX,
//             X_INIT/Y_INIT, step_clamp()
//  Revision : 1.0  initial release
// ============================================================================
package vga_ctrl_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int BOX_SIZE = 32;
   localparam int STEP     = 8;

   typedef enum logic {
      MODE_COLOUR = 1'b0,
      MODE_MOVE   = 1'b1
   } mode_e;

   localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
   localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
   localparam logic [9:0] X_INIT = 10'((H_ACTIVE - BOX_SIZE) / 2);
   localparam logic [9:0] Y_INIT = 10'((V_ACTIVE - BOX_SIZE) / 2);

   localparam logic signed [10:0] STEP_S = 11'(STEP);

   // Move one axis by +STEP (inc only), -STEP (dec only) or not at all
   // (both/neither). The sum is formed in 11-bit signed so a step below zero
   // is seen as negative and clamped instead of wrapping to a large value.
   function automatic logic [9:0] step_clamp(
      input logic [9:0] i_pos,
      input logic       i_inc,
      input logic       i_dec,
      input logic [9:0] i_max
   );
      logic signed [10:0] w_sum;
      logic        [9:0]  w_res;
      w_sum = $signed({1'b0, i_pos});
      if (i_inc && !i_dec) begin
         w_sum = w_sum + STEP_S;
      end else if (i_dec && !i_inc) begin
         w_sum = w_sum - STEP_S;
      end
      if (w_sum < 11'sd0) begin
         w_res = '0;
      end else if (w_sum > $signed({1'b0, i_max})) begin
         w_res = i_max;
      end else begin
         w_res = w_sum[9:0];
      end
      return w_res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mode_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : 2-flop synchroniser, stability counter and rising-edge press
//             pulse for one raw front-panel button.
//  Ports    : clk      in  1  system clock
//             rst      in  1  asynchronous active-high reset
//             i_raw    in  1  raw (asynchronous, bouncing) button level
//             o_press  out 1  one-cycle pulse when the debounced level rises
//  Revision : 1.0  initial release
// ============================================================================
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_press
);

   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // The counter only advances while the synced level disagrees with the
   // accepted level; any return to agreement restarts it, so a glitch shorter
   // than DEBOUNCE_CYCLES never reaches the flip.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_raw;
         r_s2    <= r_s1;
         r_press <= 1'b0;
         if (r_s2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_s2;
            r_press <= r_s2;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/vga_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_mode_ctrl
//  Purpose  : Front-panel controller for vgadriver. Debounces the buttons,
//             runs the colour/move mode FSM and produces the box fill colour
//             and position. Position changes commit only on frame_start.
//  Ports    : sysclk, reset                    clock / async active-high reset
//             change_button, set               raw buttons (mode toggle, colour latch)
//             R, G, B                          raw colour switches
//             North, South, East, West         raw direction buttons
//             frame_start                      1-cycle pulse at vertical blank
//             mode, mode_changed               current mode / toggle pulse
//             fill_rgb[2:0], box_x[9:0], box_y[9:0]
//  Revision : 1.0  initial release
// ============================================================================
module vga_mode_ctrl
   import vga_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       change_button,
   input  logic       set,
   input  logic       R,
   input  logic       G,
   input  logic       B,
   input  logic       North,
   input  logic       South,
   input  logic       East,
   input  logic       West,
   input  logic       frame_start,
   output logic       mode,
   output logic       mode_changed,
   output logic [2:0] fill_rgb,
   output logic [9:0] box_x,
   output logic [9:0] box_y
);

   // Button vector layout; the low four bits line up with the pend flags.
   localparam int BTN_CHANGE = 5;
   localparam int BTN_SET    = 4;
   localparam int BTN_N      = 3;
   localparam int BTN_S      = 2;
   localparam int BTN_E      = 1;
   localparam int BTN_W      = 0;

   logic [5:0] w_raw_btn;
   logic [5:0] w_press;
   logic [3:0] w_dir_press;

   logic [2:0] r_rgb_s1;
   logic [2:0] r_rgb_s2;

   mode_e      r_mode;
   logic       r_mode_changed;
   logic [2:0] r_fill_rgb;
   logic [9:0] r_box_x;
   logic [9:0] r_box_y;
   logic [3:0] r_pend;       // {n, s, e, w}

   assign w_raw_btn   = {change_button, set, North, South, East, West};
   assign w_dir_press = w_press[BTN_N:BTN_W];

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_debounce
         button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_button_debounce (
            .clk     (sysclk),
            .rst     (reset),
            .i_raw   (w_raw_btn[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   // Colour switches are plain levels: synchronise only, no debounce.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_rgb_s1 <= '0;
         r_rgb_s2 <= '0;
      end else begin
         r_rgb_s1 <= {R, G, B};
         r_rgb_s2 <= r_rgb_s1;
      end
   end

   // Mode FSM with its datapath. A change press has priority over everything
   // else in the same cycle: it drops a coincident set or commit and clears
   // anything pending so stale moves never apply after a mode round-trip.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_mode         <= MODE_COLOUR;
         r_mode_changed <= 1'b0;
         r_fill_rgb     <= 3'b111;
         r_box_x        <= X_INIT;
         r_box_y        <= Y_INIT;
         r_pend         <= '0;
      end else begin
         r_mode_changed <= 1'b0;
         if (w_press[BTN_CHANGE]) begin
            r_mode         <= (r_mode == MODE_COLOUR) ? MODE_MOVE : MODE_COLOUR;
            r_mode_changed <= 1'b1;
            r_pend         <= '0;
         end else begin
            case (r_mode)
               MODE_COLOUR: begin
                  if (w_press[BTN_SET]) begin
                     r_fill_rgb <= r_rgb_s2;
                  end
               end
               MODE_MOVE: begin
                  if (frame_start) begin
                     r_box_x <= step_clamp(r_box_x, r_pend[BTN_E], r_pend[BTN_W], X_MAX);
                     r_box_y <= step_clamp(r_box_y, r_pend[BTN_S], r_pend[BTN_N], Y_MAX);
                     // A press landing on the commit cycle waits for the next frame.
                     r_pend  <= w_dir_press;
                  end else begin
                     r_pend  <= r_pend | w_dir_press;
                  end
               end
               default: begin
                  r_mode <= MODE_COLOUR;
               end
            endcase
         end
      end
   end

   assign mode         = r_mode;
   assign mode_changed = r_mode_changed;
   assign fill_rgb     = r_fill_rgb;
   assign box_x        = r_box_x;
   assign box_y        = r_box_y;

endmodule
`default_nettype wire
